// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multi-cycle MIPS control unit:
//               opcode/funct codes, datapath select encodings, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;
    localparam logic [2:0] NPC_EXCEPT = 3'd4;

    localparam logic [1:0] EXT_ZERO   = 2'd0;
    localparam logic [1:0] EXT_SIGNED = 2'd1;
    localparam logic [1:0] EXT_LUI    = 2'd2;

    localparam logic [1:0] GPR_RD  = 2'd0;
    localparam logic [1:0] GPR_RT  = 2'd1;
    localparam logic [1:0] GPR_R31 = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    // ALU operation codes; the ALUOp port must be at least 3 bits wide
    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_ADDU = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_LUI  = 5'd7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXCEPT = 3'd5
    } state_e;

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu_dec.sv
// ============================================================================
// Module      : mc_alu_dec
// Description : Combinational opcode/funct decode to ALUOp plus a legality
//               flag. Optional jal/jr support under MC_CTRL_JAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] aluop,
    output logic               supported
);

    always_comb begin
        aluop     = '0;
        supported = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin aluop = ALUOP_W'(ALU_ADD);  supported = 1'b1; end
                    FN_ADDU: begin aluop = ALUOP_W'(ALU_ADDU); supported = 1'b1; end
                    FN_SUBU: begin aluop = ALUOP_W'(ALU_SUB);  supported = 1'b1; end
                    FN_SLT:  begin aluop = ALUOP_W'(ALU_SLT);  supported = 1'b1; end
                    FN_SLL:  begin aluop = ALUOP_W'(ALU_SLL);  supported = 1'b1; end
`ifdef MC_CTRL_JAL_EN
                    FN_JR:   supported = 1'b1;
`endif
                    default: ;
                endcase
            end
            OP_J:    supported = 1'b1;
`ifdef MC_CTRL_JAL_EN
            OP_JAL:  supported = 1'b1;
`endif
            OP_BEQ,
            OP_BNE:  begin aluop = ALUOP_W'(ALU_SUB); supported = 1'b1; end
            OP_ADDI: begin aluop = ALUOP_W'(ALU_ADD); supported = 1'b1; end
            OP_ORI:  begin aluop = ALUOP_W'(ALU_OR);  supported = 1'b1; end
            OP_LUI:  begin aluop = ALUOP_W'(ALU_LUI); supported = 1'b1; end
            OP_LW,
            OP_SW:   begin aluop = ALUOP_W'(ALU_ADD); supported = 1'b1; end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/EXCEPT)
//               with memory-ready stalls, timeout trap and illegal-op trap.
//               Define MC_CTRL_JAL_EN to add jal/jr support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWr,
    output logic               IRWr,
    output logic               RFWr,
    output logic               DMWr,
    output logic               DMRd,
    output logic               IMRd,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         NPCOp,
    output logic               ASel,
    output logic               BSel,
    output logic [1:0]         EXTOp,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               except,
    output logic [2:0]         state
);

    localparam int               c_cnt_w    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_e               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [ALUOP_W-1:0]   w_aluop;
    logic                 w_supported;
    logic                 w_wait;
    logic                 w_timeout;
    logic                 w_is_jal;
    logic                 w_is_jr;

    mc_alu_dec #(
        .ALUOP_W   (ALUOP_W)
    ) u_alu_dec (
        .opcode    (opcode),
        .funct     (funct),
        .aluop     (w_aluop),
        .supported (w_supported)
    );

`ifdef MC_CTRL_JAL_EN
    assign w_is_jal = (opcode == OP_JAL);
    assign w_is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);
`else
    assign w_is_jal = 1'b0;
    assign w_is_jr  = 1'b0;
`endif

    // The limit cycle only traps if memory is still not ready in it
    assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout = w_wait && (r_cnt == c_cnt_last);
    assign state     = r_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_cnt <= (w_wait && !w_timeout) ? r_cnt + c_cnt_one : '0;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready)      r_state <= S_DECODE;
                    else if (w_timeout) r_state <= S_EXCEPT;
                end
                S_DECODE: begin
                    if (!w_supported)                    r_state <= S_EXCEPT;
                    else if ((opcode == OP_J) || w_is_jal) r_state <= S_FETCH;
                    else                                 r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (opcode == OP_RTYPE)
                        r_state <= w_is_jr ? S_FETCH : S_WB;
                    else if (is_imm_alu(opcode))
                        r_state <= S_WB;
                    else if ((opcode == OP_LW) || (opcode == OP_SW))
                        r_state <= S_MEM;
                    else
                        r_state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready)      r_state <= (opcode == OP_LW) ? S_WB : S_FETCH;
                    else if (w_timeout) r_state <= S_EXCEPT;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWr   = 1'b0;
        IRWr   = 1'b0;
        RFWr   = 1'b0;
        DMWr   = 1'b0;
        DMRd   = 1'b0;
        IMRd   = 1'b0;
        ALUOp  = '0;
        NPCOp  = NPC_PLUS4;
        ASel   = 1'b0;
        BSel   = 1'b0;
        EXTOp  = EXT_ZERO;
        GPRSel = GPR_RD;
        WDSel  = WD_ALU;
        except = 1'b0;
        case (r_state)
            S_FETCH: begin
                IMRd = 1'b1;
                if (mem_ready) begin
                    IRWr = 1'b1;
                    PCWr = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_supported && ((opcode == OP_J) || w_is_jal)) begin
                    PCWr  = 1'b1;
                    NPCOp = NPC_JUMP;
                end
                if (w_supported && w_is_jal) begin
                    RFWr   = 1'b1;
                    GPRSel = GPR_R31;
                    WDSel  = WD_PC;
                end
            end
            S_EXEC: begin
                ALUOp = w_aluop;
                case (opcode)
                    OP_RTYPE: begin
                        ASel = (funct == FN_SLL);
                        if (w_is_jr) begin
                            PCWr  = 1'b1;
                            NPCOp = NPC_JR;
                        end
                    end
                    OP_ADDI: begin BSel = 1'b1; EXTOp = EXT_SIGNED; end
                    OP_ORI:  begin BSel = 1'b1; EXTOp = EXT_ZERO;   end
                    OP_LUI:  begin BSel = 1'b1; EXTOp = EXT_LUI;    end
                    OP_BEQ:  begin PCWr = Zero;  NPCOp = NPC_BRANCH; end
                    OP_BNE:  begin PCWr = !Zero; NPCOp = NPC_BRANCH; end
                    OP_LW,
                    OP_SW:   begin BSel = 1'b1; EXTOp = EXT_SIGNED; end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Address path stays selected for the whole request
                BSel  = 1'b1;
                EXTOp = EXT_SIGNED;
                ALUOp = ALUOP_W'(ALU_ADD);
                DMRd  = (opcode == OP_LW);
                DMWr  = (opcode == OP_SW);
            end
            S_WB: begin
                RFWr = 1'b1;
                if (opcode == OP_LW) begin
                    GPRSel = GPR_RT;
                    WDSel  = WD_MEM;
                end else if (opcode != OP_RTYPE) begin
                    GPRSel = GPR_RT;
                end
            end
            S_EXCEPT: begin
                PCWr   = 1'b1;
                NPCOp  = NPC_EXCEPT;
                except = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed self-checking bench for mc_ctrl (MEM_TIMEOUT=4).
//               Expectations adapt to MC_CTRL_JAL_EN for the jal step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWr, IRWr, RFWr, DMWr, DMRd, IMRd;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic       ASel, BSel;
    logic [1:0] EXTOp, GPRSel, WDSel;
    logic       except;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int dmrd_cycles;

    mc_ctrl #(
        .ALUOP_W     (5),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .opcode    (opcode),
        .funct     (funct),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RFWr      (RFWr),
        .DMWr      (DMWr),
        .DMRd      (DMRd),
        .IMRd      (IMRd),
        .ALUOp     (ALUOp),
        .NPCOp     (NPCOp),
        .ASel      (ASel),
        .BSel      (BSel),
        .EXTOp     (EXTOp),
        .GPRSel    (GPRSel),
        .WDSel     (WDSel),
        .except    (except),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs shortly after the edge, let combinational outputs settle
    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy);
        opcode    = op;
        funct     = fn;
        Zero      = z;
        mem_ready = rdy;
        #2;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        cyc;
        cyc;
        // Reset state
        chk("rst_state", state, 3'd0);
        chk("rst_imrd", IMRd, 1'b1);
        chk("rst_pcwr", PCWr, 1'b0);
        chk("rst_rfwr", RFWr, 1'b0);
        chk("rst_except", except, 1'b0);
        rstn = 1'b1;

        // add $3,$1,$2 : 0,1,2,4,0
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        chk("add_f_state", state, 3'd0);
        chk("add_f_irwr", IRWr, 1'b1);
        chk("add_f_pcwr", PCWr, 1'b1);
        chk("add_f_npc", NPCOp, 3'd0);
        chk("add_f_rfwr", RFWr, 1'b0);
        cyc;
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        chk("add_d_state", state, 3'd1);
        chk("add_d_rfwr", RFWr, 1'b0);
        chk("add_d_pcwr", PCWr, 1'b0);
        cyc;
        chk("add_e_state", state, 3'd2);
        chk("add_e_aluop", ALUOp, 5'd1);
        chk("add_e_asel", ASel, 1'b0);
        chk("add_e_rfwr", RFWr, 1'b0);
        cyc;
        chk("add_wb_state", state, 3'd4);
        chk("add_wb_rfwr", RFWr, 1'b1);
        chk("add_wb_gpr", GPRSel, 2'd0);
        chk("add_wb_wd", WDSel, 2'd0);
        cyc;
        chk("add_done_state", state, 3'd0);
        chk("add_done_rfwr", RFWr, 1'b0);

        // sll : ASel
        drive(6'h00, 6'h00, 1'b0, 1'b1);
        cyc;
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        cyc;
        chk("sll_e_asel", ASel, 1'b1);
        chk("sll_e_aluop", ALUOp, 5'd6);
        cyc;
        cyc;

        // lw with 3 wait cycles in MEM: 8 cycles total
        drive(6'h23, 6'h00, 1'b0, 1'b1);
        cyc;
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        cyc;
        chk("lw_e_state", state, 3'd2);
        chk("lw_e_bsel", BSel, 1'b1);
        chk("lw_e_ext", EXTOp, 2'd1);
        chk("lw_e_aluop", ALUOp, 5'd1);
        cyc;
        dmrd_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            drive(6'h23, 6'h00, 1'b0, (i == 3));
            chk("lw_m_state", state, 3'd3);
            chk("lw_m_dmwr", DMWr, 1'b0);
            if (DMRd === 1'b1) dmrd_cycles++;
            cyc;
        end
        chk("lw_dmrd_cycles", dmrd_cycles, 4);
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        chk("lw_wb_state", state, 3'd4);
        chk("lw_wb_rfwr", RFWr, 1'b1);
        chk("lw_wb_wd", WDSel, 2'd1);
        chk("lw_wb_gpr", GPRSel, 2'd1);
        cyc;
        chk("lw_done_state", state, 3'd0);

        // beq Zero=1 : taken
        drive(6'h04, 6'h00, 1'b1, 1'b1);
        cyc;
        drive(6'h04, 6'h00, 1'b1, 1'b0);
        cyc;
        chk("beq_e_pcwr", PCWr, 1'b1);
        chk("beq_e_npc", NPCOp, 3'd1);
        chk("beq_e_aluop", ALUOp, 5'd3);
        cyc;
        chk("beq_done_state", state, 3'd0);

        // bne Zero=1 : not taken
        drive(6'h05, 6'h00, 1'b1, 1'b1);
        cyc;
        drive(6'h05, 6'h00, 1'b1, 1'b0);
        cyc;
        chk("bne_e_state", state, 3'd2);
        chk("bne_e_pcwr", PCWr, 1'b0);
        cyc;
        chk("bne_done_state", state, 3'd0);

        // illegal opcode : EXCEPT in cycle 3
        drive(6'h3F, 6'h00, 1'b0, 1'b1);
        cyc;
        drive(6'h3F, 6'h00, 1'b0, 1'b0);
        chk("ill_d_pcwr", PCWr, 1'b0);
        cyc;
        chk("ill_x_state", state, 3'd5);
        chk("ill_x_except", except, 1'b1);
        chk("ill_x_npc", NPCOp, 3'd4);
        chk("ill_x_pcwr", PCWr, 1'b1);
        chk("ill_x_rfwr", RFWr, 1'b0);
        chk("ill_x_dmwr", DMWr, 1'b0);
        cyc;
        chk("ill_done_state", state, 3'd0);
        chk("ill_done_except", except, 1'b0);

        // FETCH timeout: 4 wait cycles -> EXCEPT
        for (int i = 0; i < 4; i++) begin
            drive(6'h08, 6'h00, 1'b0, 1'b0);
            chk("fto_wait_state", state, 3'd0);
            chk("fto_wait_imrd", IMRd, 1'b1);
            cyc;
        end
        chk("fto_state", state, 3'd5);
        cyc;

        // Ready on the 4th cycle wins -> DECODE, then addi
        for (int i = 0; i < 4; i++) begin
            drive(6'h08, 6'h00, 1'b0, (i == 3));
            cyc;
        end
        drive(6'h08, 6'h00, 1'b0, 1'b0);
        chk("frdy_state", state, 3'd1);
        cyc;
        chk("addi_e_bsel", BSel, 1'b1);
        chk("addi_e_ext", EXTOp, 2'd1);
        cyc;
        chk("addi_wb_gpr", GPRSel, 2'd1);
        chk("addi_wb_wd", WDSel, 2'd0);
        cyc;

        // ori / lui extension selects
        drive(6'h0D, 6'h00, 1'b0, 1'b1);
        cyc;
        cyc;
        chk("ori_e_ext", EXTOp, 2'd0);
        chk("ori_e_aluop", ALUOp, 5'd4);
        cyc;
        cyc;
        drive(6'h0F, 6'h00, 1'b0, 1'b1);
        cyc;
        cyc;
        chk("lui_e_ext", EXTOp, 2'd2);
        cyc;
        cyc;

        // sw zero-wait : 4 cycles
        drive(6'h2B, 6'h00, 1'b0, 1'b1);
        cyc;
        cyc;
        cyc;
        chk("sw_m_state", state, 3'd3);
        chk("sw_m_dmwr", DMWr, 1'b1);
        chk("sw_m_dmrd", DMRd, 1'b0);
        cyc;
        chk("sw_done_state", state, 3'd0);

        // sw MEM timeout
        cyc;
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        cyc;
        cyc;
        for (int i = 0; i < 4; i++) begin
            chk("mto_wait_dmwr", DMWr, 1'b1);
            cyc;
        end
        chk("mto_state", state, 3'd5);
        chk("mto_dmwr", DMWr, 1'b0);
        cyc;

        // j : 2 cycles
        drive(6'h02, 6'h00, 1'b0, 1'b1);
        cyc;
        drive(6'h02, 6'h00, 1'b0, 1'b0);
        chk("j_d_pcwr", PCWr, 1'b1);
        chk("j_d_npc", NPCOp, 3'd2);
        cyc;
        chk("j_done_state", state, 3'd0);

        // jal
        drive(6'h03, 6'h00, 1'b0, 1'b1);
        cyc;
        drive(6'h03, 6'h00, 1'b0, 1'b0);
`ifdef MC_CTRL_JAL_EN
        chk("jal_d_rfwr", RFWr, 1'b1);
        chk("jal_d_gpr", GPRSel, 2'd2);
        chk("jal_d_wd", WDSel, 2'd2);
        chk("jal_d_npc", NPCOp, 3'd2);
        cyc;
        chk("jal_done_state", state, 3'd0);
`else
        chk("jal_d_rfwr", RFWr, 1'b0);
        cyc;
        chk("jal_x_state", state, 3'd5);
        chk("jal_x_except", except, 1'b1);
        cyc;
`endif

        // Reset in the middle of a lw MEM wait aborts immediately
        drive(6'h23, 6'h00, 1'b0, 1'b1);
        cyc;
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        cyc;
        cyc;
        chk("mrst_pre_dmrd", DMRd, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mrst_state", state, 3'd0);
        chk("mrst_dmrd", DMRd, 1'b0);
        chk("mrst_imrd", IMRd, 1'b1);
        cyc;
        rstn = 1'b1;
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        chk("mrst_after_state", state, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
